// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch resolution slice.
//   DEFAULT_AW : default PC width used by branch_resolver
//   state_e    : resolver FSM state (RUN, FLUSH)
//   entry_t    : one in-flight prediction {pc, taken, alt_pc} at the default width
// -----------------------------------------------------------------------------
package branch_pkg;

    localparam int DEFAULT_AW = 32;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    typedef struct packed {
        logic [DEFAULT_AW-1:0] pc;
        logic                  taken;
        logic [DEFAULT_AW-1:0] alt_pc;
    } entry_t;

endpackage

// File: rtl/branch_fifo.sv
// -----------------------------------------------------------------------------
// branch_fifo
// Synchronous in-order FIFO holding outstanding predictions.
//   clk, rst  : clock, synchronous active-high reset
//   push_i    : write wdata_i at the tail (ignored when full)
//   pop_i     : drop the head entry (ignored when empty)
//   flush_i   : discard every entry and rewind both pointers; wins over push/pop
//   wdata_i   : entry to write
//   head_o    : combinational read of the head entry
//   cnt_o     : occupancy, 0..DEPTH
//   full_o    : cnt_o == DEPTH
//   empty_o   : cnt_o == 0
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module branch_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [W-1:0]               wdata_i,
    output logic [W-1:0]               head_o,
    output logic [$clog2(DEPTH):0]     cnt_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A full queue refuses the push even if the head leaves this same cycle.
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage carries no reset; stale slots are unreachable once cnt is 0.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i && !rst) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// -----------------------------------------------------------------------------
// branch_resolver
// Matches fetch-side predictions, in program order, against execute-side
// outcomes. Issues commit/rollback, the rollback redirect PC and the
// predictor training update.
//   clk, rst                      : clock, synchronous active-high reset
//   pred_valid/pc/taken/alt_pc    : prediction from fetch
//   pred_ready                    : prediction accepted; low stalls fetch
//   res_valid/pc/taken            : resolved branch from execute
//   commit, rollback              : one-cycle outcome pulses
//   rollback_pc                   : redirect target, held until next rollback
//   upd_valid/pc/taken            : predictor training strobe and payload
//   res_err                       : resolution matched no outstanding entry
// All outputs are registered; results appear one edge after res_valid.
// -----------------------------------------------------------------------------
module branch_resolver
    import branch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pred_valid,
    input  logic [AW-1:0] pred_pc,
    input  logic          pred_taken,
    input  logic [AW-1:0] pred_alt_pc,
    output logic          pred_ready,
    input  logic          res_valid,
    input  logic [AW-1:0] res_pc,
    input  logic          res_taken,
    output logic          commit,
    output logic          rollback,
    output logic [AW-1:0] rollback_pc,
    output logic          upd_valid,
    output logic [AW-1:0] upd_pc,
    output logic          upd_taken,
    output logic          res_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 2 * AW + 1;

    // Same layout as branch_pkg::entry_t, but sized by this instance's AW.
    typedef struct packed {
        logic [AW-1:0] pc;
        logic          taken;
        logic [AW-1:0] alt_pc;
    } ent_t;

    state_e        state_q, state_d;
    ent_t          wr_ent;
    ent_t          head_ent;
    logic [EW-1:0] head_bits;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_full;
    logic          fifo_empty;

    logic          run;
    logic          hit;
    logic          mispredict;
    logic          fifo_push;
    logic          fifo_pop;

    logic          commit_q, commit_d;
    logic          rollback_q, rollback_d;
    logic [AW-1:0] rollback_pc_q, rollback_pc_d;
    logic          upd_valid_q, upd_valid_d;
    logic [AW-1:0] upd_pc_q, upd_pc_d;
    logic          upd_taken_q, upd_taken_d;
    logic          res_err_q, res_err_d;

    assign run        = (state_q == ST_RUN);
    // Only registered state feeds ready, so execute cannot create a comb path to fetch.
    assign pred_ready = run & (fifo_cnt < CW'(DEPTH));

    assign wr_ent.pc     = pred_pc;
    assign wr_ent.taken  = pred_taken;
    assign wr_ent.alt_pc = pred_alt_pc;
    assign head_ent      = ent_t'(head_bits);

    // During FLUSH everything arriving is wrong-path and is dropped.
    assign hit        = run & res_valid & ~fifo_empty & (res_pc == head_ent.pc);
    assign mispredict = hit & (res_taken != head_ent.taken);
    // A push coinciding with a rollback belongs to the wrong path.
    assign fifo_push  = run & pred_valid & ~fifo_full & ~mispredict;
    assign fifo_pop   = hit & ~mispredict;

    branch_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (mispredict),
        .wdata_i (wr_ent),
        .head_o  (head_bits),
        .cnt_o   (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        commit_d      = 1'b0;
        rollback_d    = 1'b0;
        rollback_pc_d = rollback_pc_q;
        upd_valid_d   = 1'b0;
        upd_pc_d      = upd_pc_q;
        upd_taken_d   = upd_taken_q;
        res_err_d     = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (hit) begin
                    upd_valid_d = 1'b1;
                    upd_pc_d    = head_ent.pc;
                    upd_taken_d = res_taken;
                    if (mispredict) begin
                        rollback_d    = 1'b1;
                        rollback_pc_d = head_ent.alt_pc;
                        state_d       = ST_FLUSH;
                    end else begin
                        commit_d = 1'b1;
                    end
                end else if (res_valid) begin
                    res_err_d = 1'b1;
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            commit_q      <= 1'b0;
            rollback_q    <= 1'b0;
            rollback_pc_q <= '0;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_taken_q   <= 1'b0;
            res_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            commit_q      <= commit_d;
            rollback_q    <= rollback_d;
            rollback_pc_q <= rollback_pc_d;
            upd_valid_q   <= upd_valid_d;
            upd_pc_q      <= upd_pc_d;
            upd_taken_q   <= upd_taken_d;
            res_err_q     <= res_err_d;
        end
    end

    assign commit      = commit_q;
    assign rollback    = rollback_q;
    assign rollback_pc = rollback_pc_q;
    assign upd_valid   = upd_valid_q;
    assign upd_pc      = upd_pc_q;
    assign upd_taken   = upd_taken_q;
    assign res_err     = res_err_q;

endmodule

// File: tb/tb_branch_resolver.sv
// -----------------------------------------------------------------------------
// tb_branch_resolver
// Directed test of branch_resolver (DEPTH=4, AW=32) with hand-computed
// expectations: commit, misprediction flush, backpressure and pointer wrap,
// push/rollback collision, error cases and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_branch_resolver;

    logic        clk;
    logic        rst;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [31:0] pred_alt_pc;
    logic        pred_ready;
    logic        res_valid;
    logic [31:0] res_pc;
    logic        res_taken;
    logic        commit;
    logic        rollback;
    logic [31:0] rollback_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        res_err;

    int n_checks = 0;
    int n_pass   = 0;

    branch_resolver #(
        .DEPTH (4),
        .AW    (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pred_valid  (pred_valid),
        .pred_pc     (pred_pc),
        .pred_taken  (pred_taken),
        .pred_alt_pc (pred_alt_pc),
        .pred_ready  (pred_ready),
        .res_valid   (res_valid),
        .res_pc      (res_pc),
        .res_taken   (res_taken),
        .commit      (commit),
        .rollback    (rollback),
        .rollback_pc (rollback_pc),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .res_err     (res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic c, input logic rb,
                           input logic uv, input logic e);
        check({tag, ".commit"},    commit,    c);
        check({tag, ".rollback"},  rollback,  rb);
        check({tag, ".upd_valid"}, upd_valid, uv);
        check({tag, ".res_err"},   res_err,   e);
    endtask

    // Inputs are set after an edge, sampled at the next edge; outputs are read 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pv, input logic [31:0] ppc, input logic ptk,
                         input logic [31:0] palt, input logic rv,
                         input logic [31:0] rpc, input logic rtk);
        pred_valid  = pv;
        pred_pc     = ppc;
        pred_taken  = ptk;
        pred_alt_pc = palt;
        res_valid   = rv;
        res_pc      = rpc;
        res_taken   = rtk;
        tick();
        $display("[%0t] pred_v=%0b pc=0x%0h tk=%0b alt=0x%0h | res_v=%0b pc=0x%0h tk=%0b -> c=%0b rb=%0b rbpc=0x%0h uv=%0b upc=0x%0h ut=%0b err=%0b rdy=%0b",
                 $time, pv, ppc, ptk, palt, rv, rpc, rtk, commit, rollback,
                 rollback_pc, upd_valid, upd_pc, upd_taken, res_err, pred_ready);
        pred_valid = 1'b0;
        res_valid  = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] alt);
        drive(1'b1, pc, tk, alt, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic tk);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, pc, tk);
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0; pred_alt_pc = '0;
        res_valid = 1'b0;  res_pc = '0;  res_taken = 1'b0;
        tick();
        tick();
        chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.rollback_pc", rollback_pc, 32'h0);
        check("reset.upd_pc",      upd_pc,      32'h0);
        check("reset.upd_taken",   upd_taken,   1'b0);
        rst = 1'b0;
        check("reset.pred_ready",  pred_ready,  1'b1);

        // Correct prediction
        push(32'h100, 1'b1, 32'h108);
        resolve(32'h100, 1'b1);
        chk_out("commit", 1'b1, 1'b0, 1'b1, 1'b0);
        check("commit.upd_pc",    upd_pc,    32'h100);
        check("commit.upd_taken", upd_taken, 1'b1);
        idle();
        check("commit.pulse_end", commit, 1'b0);
        resolve(32'h100, 1'b1);             // queue drained back to 0
        chk_out("commit.empty", 1'b0, 1'b0, 1'b0, 1'b1);

        // Misprediction flush
        push(32'h100, 1'b0, 32'h140);
        push(32'h200, 1'b1, 32'h204);
        push(32'h300, 1'b1, 32'h304);
        resolve(32'h100, 1'b1);
        chk_out("mispred", 1'b0, 1'b1, 1'b1, 1'b0);
        check("mispred.rollback_pc", rollback_pc, 32'h140);
        check("mispred.upd_taken",   upd_taken,   1'b1);
        check("mispred.upd_pc",      upd_pc,      32'h100);
        check("mispred.ready_low",   pred_ready,  1'b0);
        idle();
        check("mispred.ready_back",  pred_ready,  1'b1);
        check("mispred.rb_pulse",    rollback,    1'b0);
        check("mispred.rb_pc_held",  rollback_pc, 32'h140);
        resolve(32'h200, 1'b1);
        chk_out("mispred.flushed", 1'b0, 1'b0, 1'b0, 1'b1);

        // Full / backpressure and pointer wrap
        push(32'h10, 1'b1, 32'h14);
        push(32'h20, 1'b1, 32'h24);
        push(32'h30, 1'b1, 32'h34);
        check("full.ready_at3", pred_ready, 1'b1);
        push(32'h40, 1'b1, 32'h44);
        check("full.ready_at4", pred_ready, 1'b0);
        // Fifth prediction alongside a commit-pop while full: push refused
        drive(1'b1, 32'h50, 1'b1, 32'h54, 1'b1, 32'h10, 1'b1);
        chk_out("full.pop", 1'b1, 1'b0, 1'b1, 1'b0);
        check("full.ready_rise", pred_ready, 1'b1);
        push(32'h60, 1'b1, 32'h64);         // lands in slot 0 after wrap
        check("full.ready_refill", pred_ready, 1'b0);
        resolve(32'h20, 1'b1);
        chk_out("drain.20", 1'b1, 1'b0, 1'b1, 1'b0);
        resolve(32'h30, 1'b1);
        chk_out("drain.30", 1'b1, 1'b0, 1'b1, 1'b0);
        resolve(32'h40, 1'b1);
        chk_out("drain.40", 1'b1, 1'b0, 1'b1, 1'b0);
        resolve(32'h50, 1'b1);
        chk_out("drain.50_absent", 1'b0, 1'b0, 1'b0, 1'b1);
        resolve(32'h60, 1'b1);
        chk_out("drain.60", 1'b1, 1'b0, 1'b1, 1'b0);
        check("drain.60_upd_pc", upd_pc, 32'h60);

        // Push plus commit-pop in one cycle
        push(32'h80, 1'b0, 32'h84);
        drive(1'b1, 32'h90, 1'b1, 32'h94, 1'b1, 32'h80, 1'b0);
        chk_out("pushpop.80", 1'b1, 1'b0, 1'b1, 1'b0);
        check("pushpop.80_taken", upd_taken, 1'b0);
        resolve(32'h90, 1'b1);
        chk_out("pushpop.90", 1'b1, 1'b0, 1'b1, 1'b0);
        resolve(32'h90, 1'b1);
        chk_out("pushpop.empty", 1'b0, 1'b0, 1'b0, 1'b1);

        // Push in the same cycle as a rollback, then wrong-path traffic in FLUSH
        push(32'h400, 1'b0, 32'h440);
        drive(1'b1, 32'h500, 1'b1, 32'h504, 1'b1, 32'h400, 1'b1);
        chk_out("pushrb", 1'b0, 1'b1, 1'b1, 1'b0);
        check("pushrb.rollback_pc", rollback_pc, 32'h440);
        drive(1'b1, 32'h600, 1'b1, 32'h604, 1'b1, 32'h500, 1'b1);
        chk_out("flush.ignored", 1'b0, 1'b0, 1'b0, 1'b0);
        resolve(32'h500, 1'b1);
        chk_out("pushrb.500", 1'b0, 1'b0, 1'b0, 1'b1);
        resolve(32'h600, 1'b1);
        chk_out("flush.600", 1'b0, 1'b0, 1'b0, 1'b1);

        // Error cases
        resolve(32'h100, 1'b1);
        chk_out("err.empty", 1'b0, 1'b0, 1'b0, 1'b1);
        push(32'h100, 1'b1, 32'h108);
        resolve(32'h104, 1'b1);
        chk_out("err.wrongpc", 1'b0, 1'b0, 1'b0, 1'b1);
        resolve(32'h100, 1'b1);
        chk_out("err.retained", 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset mid-operation, with a resolution pending at the reset edge
        push(32'hA00, 1'b1, 32'hA04);
        push(32'hB00, 1'b1, 32'hB04);
        push(32'hC00, 1'b1, 32'hC04);
        rst = 1'b1;
        resolve(32'hA00, 1'b1);
        rst = 1'b0;
        chk_out("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
        check("midrst.rollback_pc", rollback_pc, 32'h0);
        check("midrst.upd_pc",      upd_pc,      32'h0);
        check("midrst.upd_taken",   upd_taken,   1'b0);
        check("midrst.pred_ready",  pred_ready,  1'b1);
        resolve(32'hA00, 1'b1);
        chk_out("midrst.gone", 1'b0, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Execute-side counterpart to the branch predictor. Records every prediction fetch issues and matches it in program order against the actual outcome from execute. For each resolved branch it issues commit or rollback (with the correct redirect PC) and drives the predictor's training update. It sits between fetch, execute and the predictor; fetch stalls on `pred_ready` low.

## Interface
Parameters:
- `DEPTH`, 4, maximum number of in-flight (unresolved) predictions; power of two, at least 2.
- `AW`, 32, PC width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `pred_valid` in 1: fetch made a prediction this cycle.
- `pred_pc` in AW: PC of the predicted branch.
- `pred_taken` in 1: the prediction (1 = taken).
- `pred_alt_pc` in AW: the path not chosen (not-taken PC if predicted taken, otherwise the taken PC).
- `pred_ready` out 1: a prediction can be accepted; low means fetch stalls.
- `res_valid` in 1: execute resolved a branch this cycle.
- `res_pc` in AW: PC of the resolved branch.
- `res_taken` in 1: actual outcome.
- `commit` out 1: one-cycle pulse, prediction was correct.
- `rollback` out 1: one-cycle pulse, misprediction.
- `rollback_pc` out AW: redirect target; valid with `rollback`, held until the next rollback.
- `upd_valid` out 1: one-cycle pulse, the predictor's update strobe.
- `upd_pc` out AW: PC to train the predictor with.
- `upd_taken` out 1: outcome to train the predictor with.
- `res_err` out 1: one-cycle pulse, the resolution matched no outstanding prediction.

## Operation
- In-order queue of entries {pc, taken, alt_pc}, `DEPTH` deep, with occupancy count `cnt` (0..DEPTH).
- FSM has two states, RUN and FLUSH. Reset enters RUN.
- RUN:
  - Push: `pred_valid & pred_ready` writes an entry at the tail.
  - Resolve hit: `res_valid`, `cnt>0` and `res_pc == head.pc`. Pop the head and set `upd_valid=1`, `upd_pc=head.pc`, `upd_taken=res_taken`.
    - If `res_taken == head.taken`: `commit=1`.
    - Otherwise: `rollback=1`, `rollback_pc=head.alt_pc`, flush the whole queue (`cnt←0`, pointers←0), go to FLUSH.
  - Resolve miss: `res_valid` with `cnt==0` or a PC mismatch. `res_err=1`; no pop, no update, no commit or rollback.
- FLUSH lasts exactly one cycle. In it `pred_ready=0`, `pred_valid` and `res_valid` are ignored (wrong-path traffic), and the next state is RUN.
- `pred_ready` is `(state==RUN) & (cnt<DEPTH)`, decoded from registered state only. It has no combinational path from `res_valid`.
- Simultaneous events:
  - Push plus commit-pop: both happen; `cnt` is unchanged.
  - Push plus rollback: the push is discarded and `cnt` becomes 0.
  - When full, a push is not accepted even if a pop happens in the same cycle.
- Pointers wrap modulo `DEPTH`. `cnt` is `$clog2(DEPTH)+1` bits wide. PC compare is the full AW bits.

## Timing
- `res_valid` sampled at edge N gives `commit`/`rollback`/`upd_*`/`res_err` registered and visible after edge N, for one cycle.
- Queue writes take effect at the edge. An entry pushed at edge N can be resolved by a `res_valid` sampled at edge N+1 or later, not in the same cycle.
- After a rollback at edge N, `pred_ready=0` during cycle N+1 and returns to 1 after edge N+1.
- Reset values:
  - `commit`, `rollback`, `upd_valid`, `upd_taken`, `res_err` = 0.
  - `rollback_pc`, `upd_pc` = 0.
  - `cnt` = 0, state RUN, `pred_ready` = 1 in the first cycle after reset.
- A reset mid-operation discards all entries and any pending pulse.

## Structure
- Shared package `branch_pkg`: entry typedef {pc, taken, alt_pc}, FSM state enum {RUN, FLUSH}, default `AW`.
- One sub-module, `branch_fifo`: parameterised synchronous FIFO with push, pop, flush, count, full and empty, plus a combinational head read. `branch_resolver` holds the FSM, the compare logic and the output registers.

## Test plan
- Correct prediction: push pc=0x100, taken=1, alt=0x108; then res pc=0x100, taken=1. Expect a `commit` pulse one cycle later, `upd_valid`=1, `upd_pc`=0x100, `upd_taken`=1, and `cnt` back to 0.
- Misprediction flush: push 0x100 (taken=0, alt=0x140), then 0x200 and 0x300; resolve 0x100 taken=1. Expect `rollback`=1, `rollback_pc`=0x140, `upd_taken`=1, `cnt`=0, and `pred_ready`=0 for one cycle. A later res pc=0x200 gives `res_err`=1.
- Full / backpressure with DEPTH=4: push 4 entries and `pred_ready` drops. A fifth `pred_valid` is not stored. Commit the head and `pred_ready` rises next cycle. Drain the queue in order with pointers wrapping.
- Simultaneous push and rollback: `pred_valid` (pc=0x500) in the same cycle as a mispredict resolve. Expect `cnt`=0, and a later res pc=0x500 gives `res_err`.
- Error cases: res_valid on an empty queue gives `res_err`=1 and no `upd_valid`. A wrong PC (0x104 vs head 0x100) gives `res_err` with the head retained; a subsequent 0x100 commits.
- Reset mid-operation: 3 entries are queued, then `rst` is asserted for 1 cycle. All outputs return to their reset values, `pred_ready`=1, and a res pc equal to a former entry gives `res_err`.
